// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel enable, sync polarity, output delay and line/frame strobes.
// Optional tile-coordinate outputs are built when VGA_TIMING_TILE_EN is defined.
module vga_timing_gen #(
    parameter int H_VIS      = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VIS      = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int CW         = 10,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int PIPE_DLY   = 0,
    parameter int TILE_SHIFT = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_TILE_EN
    ,
    output logic [CW-TILE_SHIFT-1:0] tile_col,
    output logic [CW-TILE_SHIFT-1:0] tile_row,
    output logic [TILE_SHIFT-1:0]    tile_px,
    output logic [TILE_SHIFT-1:0]    tile_py
`endif
);

    localparam int H_TOTAL  = H_VIS + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VIS + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VIS + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIS + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int N_STAGES = PIPE_DLY + 1;

    if ((H_TOTAL - 1) > ((2 ** CW) - 1) || (V_TOTAL - 1) > ((2 ** CW) - 1)) begin : g_cw_check
        $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_dly_check
        $error("vga_timing_gen: PIPE_DLY must be 0..4");
    end
    if (TILE_SHIFT < 1 || TILE_SHIFT >= CW) begin : g_tile_check
        $error("vga_timing_gen: TILE_SHIFT must be 1..CW-1");
    end

    // Thresholds are one bit wider than the counters so a window ending exactly at 2^CW still decodes.
    localparam logic [CW:0]   H_VIS_C    = (CW + 1)'(H_VIS);
    localparam logic [CW:0]   V_VIS_C    = (CW + 1)'(V_VIS);
    localparam logic [CW:0]   HS_START_C = (CW + 1)'(HS_START);
    localparam logic [CW:0]   HS_END_C   = (CW + 1)'(HS_END);
    localparam logic [CW:0]   VS_START_C = (CW + 1)'(VS_START);
    localparam logic [CW:0]   VS_END_C   = (CW + 1)'(VS_END);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

    // valid marks a stage that holds a real scan position rather than a reset filler.
    typedef struct packed {
        logic          valid;
        logic          hsync;
        logic          vsync;
        logic          active;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } stage_t;

    localparam stage_t STAGE_RST = {1'b0, ~HSYNC_POL, ~VSYNC_POL, 1'b0, {(2 * CW){1'b0}}};

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW:0]   h_ext;
    logic [CW:0]   v_ext;
    stage_t        stage0_d;
    stage_t        last_in;
    stage_t        stg [N_STAGES];

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    always_comb begin
        stage0_d        = STAGE_RST;
        stage0_d.valid  = 1'b1;
        stage0_d.hsync  = (h_ext >= HS_START_C && h_ext < HS_END_C) ? HSYNC_POL : ~HSYNC_POL;
        stage0_d.vsync  = (v_ext >= VS_START_C && v_ext < VS_END_C) ? VSYNC_POL : ~VSYNC_POL;
        stage0_d.active = (h_ext < H_VIS_C) && (v_ext < V_VIS_C);
        stage0_d.x      = h_cnt;
        stage0_d.y      = v_cnt;
    end

    // The value about to enter the last stage decides the strobes.
    if (PIPE_DLY == 0) begin : g_no_dly
        assign last_in = stage0_d;
    end else begin : g_dly
        assign last_in = stg[PIPE_DLY-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            for (int i = 0; i < N_STAGES; i++) begin
                stg[i] <= STAGE_RST;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
                end else begin
                    h_cnt <= h_cnt + CW'(1);
                end
                stg[0] <= stage0_d;
                for (int i = 1; i < N_STAGES; i++) begin
                    stg[i] <= stg[i-1];
                end
                line_start  <= last_in.valid && (last_in.x == '0);
                frame_start <= last_in.valid && (last_in.x == '0) && (last_in.y == '0);
            end
        end
    end

    assign hsync  = stg[PIPE_DLY].hsync;
    assign vsync  = stg[PIPE_DLY].vsync;
    assign active = stg[PIPE_DLY].active;
    assign x_pos  = stg[PIPE_DLY].x;
    assign y_pos  = stg[PIPE_DLY].y;

`ifdef VGA_TIMING_TILE_EN
    assign tile_col = stg[PIPE_DLY].x[CW-1:TILE_SHIFT];
    assign tile_row = stg[PIPE_DLY].y[CW-1:TILE_SHIFT];
    assign tile_px  = stg[PIPE_DLY].x[TILE_SHIFT-1:0];
    assign tile_py  = stg[PIPE_DLY].y[TILE_SHIFT-1:0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance plus two small-raster instances
// (PIPE_DLY=0 and PIPE_DLY=2 with active-high hsync) sharing a pixel enable.
module tb_vga_timing_gen;

    localparam int CW   = 10;
    localparam int S_HT = 15;   // 8 + 2 + 3 + 2
    localparam int S_VT = 8;    // 4 + 1 + 2 + 1
    localparam int W    = 2 * CW + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_s = 1'b0;

    logic d_hs, d_vs, d_act, d_ls, d_fs;
    logic [CW-1:0] d_x, d_y;
    logic a_hs, a_vs, a_act, a_ls, a_fs;
    logic [CW-1:0] a_x, a_y;
    logic b_hs, b_vs, b_act, b_ls, b_fs;
    logic [CW-1:0] b_x, b_y;
`ifdef VGA_TIMING_TILE_EN
    logic [CW-6:0] d_tc, d_tr, a_tc, a_tr, b_tc, b_tr;
    logic [4:0]    d_tx, d_ty, a_tx, a_ty, b_tx, b_ty;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit act;
    } vec_t;

    vec_t vecs[13];
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .pix_en(1'b1),
        .hsync(d_hs), .vsync(d_vs), .active(d_act), .x_pos(d_x), .y_pos(d_y),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_TILE_EN
        , .tile_col(d_tc), .tile_row(d_tr), .tile_px(d_tx), .tile_py(d_ty)
`endif
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VIS(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_DLY(0)
    ) u_a (
        .clk(clk), .rst(rst), .pix_en(pix_s),
        .hsync(a_hs), .vsync(a_vs), .active(a_act), .x_pos(a_x), .y_pos(a_y),
        .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_TILE_EN
        , .tile_col(a_tc), .tile_row(a_tr), .tile_px(a_tx), .tile_py(a_ty)
`endif
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VIS(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .PIPE_DLY(2), .HSYNC_POL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(pix_s),
        .hsync(b_hs), .vsync(b_vs), .active(b_act), .x_pos(b_x), .y_pos(b_y),
        .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_TILE_EN
        , .tile_col(b_tc), .tile_row(b_tr), .tile_px(b_tx), .tile_py(b_ty)
`endif
    );

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected small-raster stage word for linear scan index idx: {hs_asserted, vs_asserted, active, x, y}.
    function automatic logic [W-1:0] model(input int idx);
        int x, y;
        x = idx % S_HT;
        y = (idx / S_HT) % S_VT;
        return {(x >= 10 && x < 13), (y >= 5 && y < 7), (x < 8 && y < 4), CW'(x), CW'(y)};
    endfunction

    task automatic check_a(input logic [W-1:0] e, input bit en_edge);
        int x, y;
        x = int'(e[2*CW-1:CW]);
        y = int'(e[CW-1:0]);
        chk("a_x", a_x, x);
        chk("a_y", a_y, y);
        chk("a_hsync", a_hs, !e[W-1]);
        chk("a_vsync", a_vs, !e[W-2]);
        chk("a_active", a_act, e[W-3]);
        chk("a_line_start", a_ls, en_edge && x == 0);
        chk("a_frame_start", a_fs, en_edge && x == 0 && y == 0);
    endtask

    task automatic check_b(input logic [W-1:0] e, input bit en_edge);
        int x, y;
        x = int'(e[2*CW-1:CW]);
        y = int'(e[CW-1:0]);
        chk("b_x", b_x, x);
        chk("b_y", b_y, y);
        chk("b_hsync", b_hs, e[W-1]);
        chk("b_vsync", b_vs, !e[W-2]);
        chk("b_active", b_act, e[W-3]);
        chk("b_line_start", b_ls, en_edge && x == 0);
        chk("b_frame_start", b_fs, en_edge && x == 0 && y == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits, last_ls, last_fs, k, hs_low;
        logic [W-1:0] ea, eb, prev_a, prev_b;
        bit found;

        vecs[0]  = '{0, 0, 0, 0, 1};
        vecs[1]  = '{7, 3, 0, 0, 1};
        vecs[2]  = '{8, 0, 0, 0, 0};
        vecs[3]  = '{9, 1, 0, 0, 0};
        vecs[4]  = '{10, 2, 1, 0, 0};
        vecs[5]  = '{12, 2, 1, 0, 0};
        vecs[6]  = '{13, 2, 0, 0, 0};
        vecs[7]  = '{14, 4, 0, 0, 0};
        vecs[8]  = '{3, 4, 0, 0, 0};
        vecs[9]  = '{0, 5, 0, 1, 0};
        vecs[10] = '{14, 6, 0, 1, 0};
        vecs[11] = '{11, 6, 1, 1, 0};
        vecs[12] = '{5, 7, 0, 0, 0};

        // Reset state of every instance.
        rst = 1'b1;
        pix_s = 1'b1;
        repeat (3) tick();
        check_a('0, 1'b0);
        check_b('0, 1'b0);
        chk("d_rst_hsync", d_hs, 1);
        chk("d_rst_vsync", d_vs, 1);
        chk("d_rst_active", d_act, 0);
        chk("d_rst_x", d_x, 0);
        chk("d_rst_y", d_y, 0);
        chk("d_rst_line_start", d_ls, 0);
        chk("d_rst_frame_start", d_fs, 0);

        // Two small frames at full enable; PIPE_DLY=2 copy checked through the expected queue.
        rst = 1'b0;
        hits = 0;
        last_ls = -1;
        last_fs = -1;
        exp_q.delete();
        for (k = 1; k <= 2 * S_HT * S_VT; k++) begin
            tick();
            if (k == 1) begin
                chk("d_first_active", d_act, 1);
                chk("d_first_x", d_x, 0);
                chk("d_first_y", d_y, 0);
                chk("d_first_line_start", d_ls, 1);
                chk("d_first_frame_start", d_fs, 1);
                chk("d_first_hsync", d_hs, 1);
                chk("d_first_vsync", d_vs, 1);
            end
            ea = model(k - 1);
            check_a(ea, 1'b1);
            exp_q.push_back(ea);
            if (k < 3) check_b('0, 1'b0);
            else check_b(exp_q.pop_front(), 1'b1);
            for (int i = 0; i < 13; i++) begin
                if (int'(ea[2*CW-1:CW]) == vecs[i].x && int'(ea[CW-1:0]) == vecs[i].y) begin
                    hits++;
                    chk("vec_hsync", a_hs, !vecs[i].hs);
                    chk("vec_vsync", a_vs, !vecs[i].vs);
                    chk("vec_active", a_act, vecs[i].act);
                end
            end
            if (a_ls) begin
                if (last_ls >= 0) chk("a_line_period", k - last_ls, S_HT);
                last_ls = k;
            end
            if (a_fs) begin
                if (last_fs >= 0) chk("a_frame_period", k - last_fs, S_HT * S_VT);
                last_fs = k;
            end
        end
        chk("vec_hits", hits, 26);

        // Pixel enable one clock in four.
        rst = 1'b1;
        tick();
        check_a('0, 1'b0);
        check_b('0, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        k = 0;
        prev_a = '0;
        prev_b = '0;
        last_ls = -1;
        last_fs = -1;
        for (int c = 0; c < 4 * 250; c++) begin
            pix_s = (c % 4 == 0);
            tick();
            if (pix_s) begin
                k++;
                ea = model(k - 1);
                exp_q.push_back(ea);
                eb = (k >= 3) ? exp_q.pop_front() : '0;
                check_a(ea, 1'b1);
                check_b(eb, k >= 3);
                prev_a = ea;
                prev_b = eb;
            end else begin
                check_a(prev_a, 1'b0);
                check_b(prev_b, 1'b0);
            end
            if (a_ls) begin
                if (last_ls >= 0) chk("slow_line_period", c - last_ls, 4 * S_HT);
                last_ls = c;
            end
            if (a_fs) begin
                if (last_fs >= 0) chk("slow_frame_period", c - last_fs, 4 * S_HT * S_VT);
                last_fs = c;
            end
        end

        // Reset in the middle of a frame.
        pix_s = 1'b1;
        found = 1'b0;
        for (int g = 0; g < 200 && !found; g++) begin
            tick();
            if (a_x == 10'd6 && a_y == 10'd2) found = 1'b1;
        end
        chk("reach_mid_frame", found, 1);
        rst = 1'b1;
        tick();
        check_a('0, 1'b0);
        check_b('0, 1'b0);
        chk("d_midrst_x", d_x, 0);
        chk("d_midrst_line_start", d_ls, 0);
        rst = 1'b0;
        tick();
        check_a(model(0), 1'b1);
        check_b('0, 1'b0);
        tick();
        check_a(model(1), 1'b1);
        check_b('0, 1'b0);
        tick();
        check_a(model(2), 1'b1);
        check_b(model(0), 1'b1);

        // One full line of the default 640x480 timing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hs_low = 0;
        last_ls = -1;
        for (k = 1; k <= 801; k++) begin
            int x;
            tick();
            x = (k - 1) % 800;
            chk("d_x", d_x, x);
            chk("d_y", d_y, (k - 1) / 800);
            chk("d_active", d_act, x < 640);
            chk("d_hsync", d_hs, !(x >= 656 && x < 752));
            chk("d_line_start", d_ls, x == 0);
            if (k <= 800 && !d_hs) hs_low++;
            if (d_ls) begin
                if (last_ls >= 0) chk("d_line_period", k - last_ls, 800);
                last_ls = k;
            end
`ifdef VGA_TIMING_TILE_EN
            if (x == 100) begin
                chk("tile_col", d_tc, 3);
                chk("tile_px", d_tx, 4);
                chk("tile_row", d_tr, 0);
                chk("tile_py", d_ty, 0);
            end
`endif
        end
        chk("d_hsync_width", hs_low, 96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
